// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the uart transmitter: buffers host writes and issues one
// transmit pulse per byte, waiting on the uart's is_transmitting handshake.
module uart_tx_queue #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int START_TIMEOUT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_flags,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              tx_lost,
  output logic              busy,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  input  logic              is_transmitting
);

  localparam int TW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  logic                full_q, empty_q;
  logic                ovf_q, ovf_d, lost_q, lost_d;
  logic                transmit_q, transmit_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                push, pop, lost_set;

  // Full is judged on the registered count, so a pop in the same cycle
  // never frees room for a write.
  assign push = wr_en && !full_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pop        = 1'b0;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    lost_set   = 1'b0;
    case (state_q)
      IDLE: if (!empty_q && !is_transmitting) begin
        pop        = 1'b1;
        transmit_d = 1'b1;
        tx_byte_d  = mem[rd_ptr_q];
        timer_d    = '0;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (is_transmitting) state_d = WAIT_DONE;
        else if (timer_q == TW'(START_TIMEOUT)) begin
          lost_set = 1'b1;
          state_d  = IDLE;
        end else timer_d = timer_q + 1'b1;
      end
      WAIT_DONE: if (!is_transmitting) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    level_d = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    ovf_d   = (wr_en && full_q) ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
    lost_d  = lost_set ? 1'b1 : (clr_flags ? 1'b0 : lost_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      lost_q     <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      full_q     <= (level_d == (ADDR_W+1)'(DEPTH));
      empty_q    <= (level_d == '0);
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      timer_q    <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign tx_lost  = lost_q;
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = !empty_q || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed table/sequences plus random traffic
// against a queue-level reference model and a simple uart model.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int TO = 3;

  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, clr_flags = 1'b0, is_transmitting = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, overflow, tx_lost, busy, transmit;
  logic [ADDR_W:0] level;
  logic [7:0] tx_byte;

  uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_flags(clr_flags),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .tx_lost(tx_lost),
    .busy(busy), .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] m_q[$];
  logic [7:0] rx[$];
  int m_level = 0, lost_cd = 0, ucnt = 0, frame = 4, npulse = 0;
  bit m_ovf = 0, m_lost = 0, hold = 0, dead = 0, rnd_frame = 0, prev_tx = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: reference model and uart model advance, then outputs are checked.
  task automatic tick();
    bit w = wr_en, c = clr_flags, r = rst, prev_is = is_transmitting;
    logic [7:0] d = wr_data;
    bit acc, lset;
    @(posedge clk); #1;
    if (r) begin
      m_q.delete(); m_level = 0; m_ovf = 0; m_lost = 0; lost_cd = 0; ucnt = 0;
      chk("rst_transmit", transmit, 0);
    end else begin
      acc = w && (m_level != DEPTH);
      lset = 0;
      if (lost_cd > 0) begin lost_cd--; if (lost_cd == 0) lset = 1; end
      if (transmit) begin
        chk("pulse_width", prev_tx, 0);
        chk("pulse_while_uart_idle", prev_is, 0);
        if (m_q.size() == 0) chk("pop_from_empty", 1, 0);
        else chk("tx_byte", tx_byte, m_q.pop_front());
        m_level--;
        npulse++;
        if (!dead) begin
          rx.push_back(tx_byte);
          ucnt = rnd_frame ? int'($urandom_range(1, 8)) : frame;
        end else lost_cd = TO + 1;
      end else if (ucnt > 0) ucnt--;
      if (acc) begin m_q.push_back(d); m_level++; end
      if (w && !acc) m_ovf = 1; else if (c) m_ovf = 0;
      if (lset) m_lost = 1; else if (c) m_lost = 0;
    end
    is_transmitting = hold || (ucnt > 0);
    prev_tx = transmit;
    chk("level", int'(level), m_level);
    chk("full", full, m_level == DEPTH);
    chk("empty", empty, m_level == 0);
    chk("overflow", overflow, m_ovf);
    chk("tx_lost", tx_lost, m_lost);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    wr_en = 0; clr_flags = 0;
    while ((busy || m_level != 0 || is_transmitting) && n < budget) begin tick(); n++; end
    chk("drain_in_budget", n < budget, 1);
  endtask

  typedef struct {
    bit wr; logic [7:0] d; bit clr; int lvl; bit full; bit ovf;
  } vec_t;
  vec_t vt[18];

  initial begin
    int n;
    for (int i = 0; i < 17; i++)
      vt[i] = '{1'b1, 8'(8'h10 + i), 1'b0, (i + 1 > DEPTH) ? DEPTH : i + 1, i >= DEPTH - 1, i == DEPTH};
    vt[17] = '{1'b0, 8'h00, 1'b1, DEPTH, 1'b1, 1'b0};

    // reset state
    rst = 1; tick(); rst = 0;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_busy", busy, 0);
    chk("rst_tx_byte", tx_byte, 8'h00); chk("rst_transmit", transmit, 0);

    // single byte A5
    frame = 5;
    wr_en = 1; wr_data = 8'hA5; tick();
    chk("a5_level1", int'(level), 1); chk("a5_no_tx_yet", transmit, 0); chk("a5_busy", busy, 1);
    wr_en = 0; tick();
    chk("a5_transmit", transmit, 1); chk("a5_byte", tx_byte, 8'hA5); chk("a5_level0", int'(level), 0);
    tick();
    chk("a5_pulse_1cyc", transmit, 0);
    n = 0;
    do begin tick(); chk("a5_busy_held", busy, 1); n++; end while (is_transmitting && n < 50);
    tick(); chk("a5_busy_drop", busy, 0);

    // 01..05 back to back
    rx.delete(); n = npulse; frame = 4;
    for (int i = 1; i <= 5; i++) begin wr_en = 1; wr_data = 8'(i); tick(); end
    drain(500);
    chk("seq_pulses", npulse - n, 5); chk("seq_rx_count", rx.size(), 5);
    for (int i = 0; i < 5 && i < rx.size(); i++) chk("seq_rx_order", rx[i], i + 1);

    // fill while uart busy, 17th dropped, clr_flags, then full+pop collision
    rx.delete(); hold = 1; is_transmitting = 1; frame = 3;
    for (int i = 0; i < 18; i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].d; clr_flags = vt[i].clr; tick();
      chk("tbl_level", int'(level), vt[i].lvl);
      chk("tbl_full", full, vt[i].full);
      chk("tbl_ovf", overflow, vt[i].ovf);
    end
    clr_flags = 0; hold = 0; is_transmitting = (ucnt > 0);
    wr_en = 1; wr_data = 8'hEE; tick();
    chk("collide_level", int'(level), DEPTH - 1); chk("collide_ovf", overflow, 1);
    chk("collide_transmit", transmit, 1); chk("collide_byte", tx_byte, 8'h10);
    drain(2000);
    chk("drain16_count", rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) chk("drain16_data", rx[i], 8'h10 + i);

    // dead uart: start timeout
    clr_flags = 1; tick(); clr_flags = 0;
    dead = 1;
    wr_en = 1; wr_data = 8'hD1; tick(); wr_data = 8'hD2; tick(); wr_en = 0;
    chk("dead_pulse1", transmit, 1); chk("dead_byte1", tx_byte, 8'hD1);
    for (int i = 0; i < TO; i++) begin tick(); chk("dead_not_lost_yet", tx_lost, 0); end
    tick(); chk("dead_lost", tx_lost, 1); chk("dead_busy_queued", busy, 1);
    tick(); chk("dead_pulse2", transmit, 1); chk("dead_byte2", tx_byte, 8'hD2);
    for (int i = 0; i < TO + 1; i++) tick();
    clr_flags = 1; tick(); clr_flags = 0;
    chk("dead_clr", tx_lost, 0); chk("dead_idle", busy, 0);
    dead = 0;

    // reset while in WAIT_DONE with 4 queued
    frame = 20;
    for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = 8'(8'h30 + i); tick(); end
    wr_en = 0;
    chk("rstmid_level4", int'(level), 4); chk("rstmid_uart_busy", is_transmitting, 1);
    rst = 1; tick(); rst = 0;
    chk("rstmid_level0", int'(level), 0); chk("rstmid_empty", empty, 1);
    chk("rstmid_transmit", transmit, 0); chk("rstmid_busy", busy, 0);
    tick(); chk("rstmid_quiet", transmit, 0);

    // random traffic
    rnd_frame = 1;
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      clr_flags = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 200) == 0) begin hold = !hold; end
      is_transmitting = hold || (ucnt > 0);
      tick();
    end
    hold = 0; is_transmitting = (ucnt > 0);
    drain(2000);
    chk("rand_drained", int'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
